bf_fetch_ctrl: RTL and testbench

//  Brainfuck instruction sequencer: walks a program ROM (1-cycle registered read), decodes

---
 rtl/bf_fetch_ctrl.sv | 302 ++++++++++++++++++++++++++++++
 tb/tb_bf_fetch_ctrl.sv | 270 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/bf_fetch_ctrl.sv
// bf_fetch_ctrl -- Brainfuck instruction sequencer.
// Walks a registered-read program ROM, issues data ops (+ - > < . ,) to the
// cell/IO datapath over a valid/ready handshake, and resolves [ ] itself by
// scanning the ROM for the matching bracket.
// Optional feature macro: BF_CTRL_STATS_EN adds the 16-bit 'retired' counter
// (accepted ops plus executed brackets, saturating, frozen once halted).
module bf_fetch_ctrl #(
   parameter int ADDR_W  = 4,
   parameter int DEPTH_W = 8
) (
   input  logic              clk,
   input  logic              reset,
   output logic [ADDR_W-1:0] romAddr,
   input  logic [7:0]        romData,
   output logic              opValid,
   output logic [2:0]        opCode,
   input  logic              opReady,
   input  logic              cellZero,
   output logic              halted,
`ifdef BF_CTRL_STATS_EN
   output logic              error,
   output logic [15:0]       retired
`else
   output logic              error
`endif
);

   typedef enum logic [2:0] {
      S_FETCH,
      S_DECODE,
      S_ISSUE,
      S_SF_FETCH,
      S_SF_DECODE,
      S_SB_FETCH,
      S_SB_DECODE,
      S_HALT
   } state_t;

   localparam logic [ADDR_W-1:0]  PC_MAX    = '1;
   localparam logic [ADDR_W-1:0]  PC_ZERO   = '0;
   localparam logic [DEPTH_W-1:0] DEPTH_MAX = '1;
   localparam logic [DEPTH_W-1:0] DEPTH_ONE = DEPTH_W'(1);

   localparam logic [7:0] CH_INC   = 8'h2B;
   localparam logic [7:0] CH_DEC   = 8'h2D;
   localparam logic [7:0] CH_RIGHT = 8'h3E;
   localparam logic [7:0] CH_LEFT  = 8'h3C;
   localparam logic [7:0] CH_OUT   = 8'h2E;
   localparam logic [7:0] CH_IN    = 8'h2C;
   localparam logic [7:0] CH_OPEN  = 8'h5B;
   localparam logic [7:0] CH_CLOSE = 8'h5D;
   localparam logic [7:0] CH_END   = 8'h00;

   state_t             state_q, state_d;
   logic [ADDR_W-1:0]  pc_q, pc_d;
   logic [DEPTH_W-1:0] depth_q, depth_d;
   logic               opValid_q, opValid_d;
   logic [2:0]         opCode_q, opCode_d;
   logic               halted_q, halted_d;
   logic               error_q, error_d;
   logic               count_en;

   logic               pc_last;
   logic               pc_first;
   logic [ADDR_W-1:0]  pc_inc;
   logic [ADDR_W-1:0]  pc_dec;
   logic               is_op;
   logic [2:0]         op_code;

   assign romAddr = pc_q;
   assign opValid = opValid_q;
   assign opCode  = opCode_q;
   assign halted  = halted_q;
   assign error   = error_q;

   assign pc_last  = (pc_q == PC_MAX);
   assign pc_first = (pc_q == PC_ZERO);
   assign pc_inc   = pc_q + ADDR_W'(1);
   assign pc_dec   = pc_q - ADDR_W'(1);

   // Map a ROM byte onto a datapath opcode; is_op flags the six data commands.
   always_comb begin
      is_op   = 1'b1;
      op_code = 3'd0;
      case (romData)
         CH_INC:   op_code = 3'd0;
         CH_DEC:   op_code = 3'd1;
         CH_RIGHT: op_code = 3'd2;
         CH_LEFT:  op_code = 3'd3;
         CH_OUT:   op_code = 3'd4;
         CH_IN:    op_code = 3'd5;
         default:  is_op   = 1'b0;
      endcase
   end

   // Next-state logic: fetch/decode/issue sequencing and bracket scans.
   // Leaving the last address by pc+1 is a normal end; running off either
   // end of the ROM while hunting a bracket is a fault.
   always_comb begin
      state_d   = state_q;
      pc_d      = pc_q;
      depth_d   = depth_q;
      opValid_d = opValid_q;
      opCode_d  = opCode_q;
      halted_d  = halted_q;
      error_d   = error_q;
      count_en  = 1'b0;

      case (state_q)
         S_FETCH: state_d = S_DECODE;

         S_DECODE: begin
            if (romData == CH_END) begin
               state_d  = S_HALT;
               halted_d = 1'b1;
            end else if (is_op) begin
               opCode_d  = op_code;
               opValid_d = 1'b1;
               state_d   = S_ISSUE;
            end else if (romData == CH_OPEN) begin
               count_en = 1'b1;
               if (!cellZero) begin
                  if (pc_last) begin
                     state_d  = S_HALT;
                     halted_d = 1'b1;
                  end else begin
                     pc_d    = pc_inc;
                     state_d = S_FETCH;
                  end
               end else if (pc_last) begin
                  // Nothing left to scan: the '[' can never be matched.
                  state_d  = S_HALT;
                  halted_d = 1'b1;
                  error_d  = 1'b1;
               end else begin
                  depth_d = DEPTH_ONE;
                  pc_d    = pc_inc;
                  state_d = S_SF_FETCH;
               end
            end else if (romData == CH_CLOSE) begin
               count_en = 1'b1;
               if (cellZero) begin
                  if (pc_last) begin
                     state_d  = S_HALT;
                     halted_d = 1'b1;
                  end else begin
                     pc_d    = pc_inc;
                     state_d = S_FETCH;
                  end
               end else if (pc_first) begin
                  state_d  = S_HALT;
                  halted_d = 1'b1;
                  error_d  = 1'b1;
               end else begin
                  depth_d = DEPTH_ONE;
                  pc_d    = pc_dec;
                  state_d = S_SB_FETCH;
               end
            end else begin
               // Comment/NOP byte.
               if (pc_last) begin
                  state_d  = S_HALT;
                  halted_d = 1'b1;
               end else begin
                  pc_d    = pc_inc;
                  state_d = S_FETCH;
               end
            end
         end

         S_ISSUE: begin
            if (opReady) begin
               opValid_d = 1'b0;
               count_en  = 1'b1;
               if (pc_last) begin
                  state_d  = S_HALT;
                  halted_d = 1'b1;
               end else begin
                  pc_d    = pc_inc;
                  state_d = S_FETCH;
               end
            end
         end

         S_SF_FETCH: state_d = S_SF_DECODE;

         S_SF_DECODE: begin
            if (romData == CH_END) begin
               state_d  = S_HALT;
               halted_d = 1'b1;
               error_d  = 1'b1;
            end else if (romData == CH_CLOSE && depth_q == DEPTH_ONE) begin
               // Matched: resume just past the ']'.
               depth_d = '0;
               if (pc_last) begin
                  state_d  = S_HALT;
                  halted_d = 1'b1;
               end else begin
                  pc_d    = pc_inc;
                  state_d = S_FETCH;
               end
            end else if (romData == CH_OPEN && depth_q == DEPTH_MAX) begin
               state_d  = S_HALT;
               halted_d = 1'b1;
               error_d  = 1'b1;
            end else begin
               if (romData == CH_OPEN)  depth_d = depth_q + DEPTH_ONE;
               if (romData == CH_CLOSE) depth_d = depth_q - DEPTH_ONE;
               if (pc_last) begin
                  state_d  = S_HALT;
                  halted_d = 1'b1;
                  error_d  = 1'b1;
               end else begin
                  pc_d    = pc_inc;
                  state_d = S_SF_FETCH;
               end
            end
         end

         S_SB_FETCH: state_d = S_SB_DECODE;

         S_SB_DECODE: begin
            if (romData == CH_OPEN && depth_q == DEPTH_ONE) begin
               // Matched: resume at the first instruction of the loop body.
               depth_d = '0;
               if (pc_last) begin
                  state_d  = S_HALT;
                  halted_d = 1'b1;
               end else begin
                  pc_d    = pc_inc;
                  state_d = S_FETCH;
               end
            end else if (romData == CH_CLOSE && depth_q == DEPTH_MAX) begin
               state_d  = S_HALT;
               halted_d = 1'b1;
               error_d  = 1'b1;
            end else begin
               if (romData == CH_CLOSE) depth_d = depth_q + DEPTH_ONE;
               if (romData == CH_OPEN)  depth_d = depth_q - DEPTH_ONE;
               if (pc_first) begin
                  state_d  = S_HALT;
                  halted_d = 1'b1;
                  error_d  = 1'b1;
               end else begin
                  pc_d    = pc_dec;
                  state_d = S_SB_FETCH;
               end
            end
         end

         S_HALT: begin
            opValid_d = 1'b0;
            halted_d  = 1'b1;
         end

         default: state_d = S_HALT;
      endcase
   end

   // State register; reset abandons any pending op or scan immediately.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q   <= S_FETCH;
         pc_q      <= '0;
         depth_q   <= '0;
         opValid_q <= 1'b0;
         opCode_q  <= 3'd0;
         halted_q  <= 1'b0;
         error_q   <= 1'b0;
      end else begin
         state_q   <= state_d;
         pc_q      <= pc_d;
         depth_q   <= depth_d;
         opValid_q <= opValid_d;
         opCode_q  <= opCode_d;
         halted_q  <= halted_d;
         error_q   <= error_d;
      end
   end

`ifdef BF_CTRL_STATS_EN
   logic [15:0] retired_q, retired_d;

   assign retired = retired_q;

   // Saturating retire count; count_en never fires in HALT so it freezes there.
   always_comb begin
      retired_d = retired_q;
      if (count_en && retired_q != 16'hFFFF) retired_d = retired_q + 16'd1;
   end

   // Retire counter register.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) retired_q <= '0;
      else       retired_q <= retired_d;
   end
`else
   logic unused_count_en;
   assign unused_count_en = count_en;
`endif

endmodule

// File: tb/tb_bf_fetch_ctrl.sv
// Directed bench for bf_fetch_ctrl: ROM model with registered read, a small
// cell/pointer datapath model, and one task per scenario.
module tb_bf_fetch_ctrl;

   logic       clk = 1'b0;
   logic       reset;
   logic [3:0] romAddr;
   logic [7:0] romData;
   logic       opValid;
   logic [2:0] opCode;
   logic       opReady;
   logic       cellZero;
   logic       halted;
   logic       error;
`ifdef BF_CTRL_STATS_EN
   logic [15:0] retired;
`endif

   logic [7:0] rom [16];
   logic [7:0] cells [4];
   logic [1:0] ptr;
   logic       cz_force;
   logic       cz_val;
   int         op_log[$];
   int         out_log[$];

   int n_cmp = 0;
   int n_bad = 0;

   always #5 clk = ~clk;

   bf_fetch_ctrl #(.ADDR_W(4), .DEPTH_W(8)) dut (
      .clk(clk),
      .reset(reset),
      .romAddr(romAddr),
      .romData(romData),
      .opValid(opValid),
      .opCode(opCode),
      .opReady(opReady),
      .cellZero(cellZero),
      .halted(halted),
`ifdef BF_CTRL_STATS_EN
      .error(error),
      .retired(retired)
`else
      .error(error)
`endif
   );

   // Registered ROM read.
   always @(posedge clk) romData <= rom[romAddr];

   assign cellZero = cz_force ? cz_val : (cells[ptr] == 8'd0);

   // Datapath model: applies each accepted op and logs it.
   always @(posedge clk or posedge reset) begin
      if (reset) begin
         for (int i = 0; i < 4; i++) cells[i] <= 8'd0;
         ptr <= 2'd0;
         op_log.delete();
         out_log.delete();
      end else if (opValid && opReady) begin
         op_log.push_back(int'(opCode));
         case (opCode)
            3'd0: cells[ptr] <= cells[ptr] + 8'd1;
            3'd1: cells[ptr] <= cells[ptr] - 8'd1;
            3'd2: ptr <= ptr + 2'd1;
            3'd3: ptr <= ptr - 2'd1;
            3'd4: out_log.push_back(int'(cells[ptr]));
            default: ;
         endcase
      end
   end

   task automatic start(input string prog, input logic rdy, input logic force_cz, input logic cz);
      reset = 1'b1;
      for (int i = 0; i < 16; i++) rom[i] = (i < prog.len()) ? prog[i] : 8'h00;
      opReady  = rdy;
      cz_force = force_cz;
      cz_val   = cz;
      @(negedge clk);
      @(negedge clk);
      reset = 1'b0;
   endtask

   task automatic wait_halt(input string name, input int budget);
      for (int i = 0; i < budget && !halted; i++) @(negedge clk);
      n_cmp++;
      if (halted !== 1'b1) begin
         n_bad++;
         $display("FAIL %s: halted=%b after %0d cycles, required 1", name, halted, budget);
      end
   endtask

   task automatic test_reset();
      start("  +", 1'b0, 1'b1, 1'b0);
      #1;
      n_cmp++;
      if ({romAddr, opValid, opCode, halted, error} !== {4'd0, 1'b0, 3'd0, 1'b0, 1'b0}) begin
         n_bad++;
         $display("FAIL reset_state: addr=%0d vld=%b code=%0d halt=%b err=%b, required 0/0/0/0/0",
                  romAddr, opValid, opCode, halted, error);
      end
      // Run until the '+' stalls in ISSUE at pc=2, then reset asynchronously.
      for (int i = 0; i < 20 && !opValid; i++) @(negedge clk);
      n_cmp++;
      if ({opValid, romAddr} !== {1'b1, 4'd2}) begin
         n_bad++;
         $display("FAIL reset_pre: vld=%b addr=%0d, required 1/2", opValid, romAddr);
      end
      #2 reset = 1'b1;
      #1;
      n_cmp++;
      if ({romAddr, opValid, halted, error} !== {4'd0, 1'b0, 1'b0, 1'b0}) begin
         n_bad++;
         $display("FAIL reset_mid: addr=%0d vld=%b halt=%b err=%b, required 0/0/0/0",
                  romAddr, opValid, halted, error);
      end
      @(negedge clk);
      reset = 1'b0;
   endtask

   task automatic test_basic();
      start("+>.", 1'b1, 1'b0, 1'b0);
      wait_halt("basic_halt", 200);
      n_cmp++;
      if (op_log.size() != 3 || op_log[0] != 0 || op_log[1] != 2 || op_log[2] != 4) begin
         n_bad++;
         $display("FAIL basic_ops: got %0d ops %p, required 3 ops 0,2,4", op_log.size(), op_log);
      end
      n_cmp++;
      if ({error, romAddr} !== {1'b0, 4'd3}) begin
         n_bad++;
         $display("FAIL basic_end: err=%b pc=%0d, required 0/3", error, romAddr);
      end
`ifdef BF_CTRL_STATS_EN
      n_cmp++;
      if (retired !== 16'd3) begin
         n_bad++;
         $display("FAIL basic_retired: got %0d, required 3", retired);
      end
`endif
      // Frozen in HALT.
      repeat (4) @(negedge clk);
      n_cmp++;
      if ({halted, opValid, romAddr} !== {1'b1, 1'b0, 4'd3}) begin
         n_bad++;
         $display("FAIL halt_frozen: halt=%b vld=%b pc=%0d, required 1/0/3", halted, opValid, romAddr);
      end
   endtask

   task automatic test_stall();
      int bad;
      start("+.", 1'b0, 1'b0, 1'b0);
      for (int i = 0; i < 20 && !opValid; i++) @(negedge clk);
      bad = 0;
      for (int i = 0; i < 5; i++) begin
         if ({opValid, opCode, romAddr} !== {1'b1, 3'd0, 4'd0}) bad++;
         @(negedge clk);
      end
      n_cmp++;
      if (bad != 0) begin
         n_bad++;
         $display("FAIL stall_hold: %0d of 5 cycles not holding vld=1 code=0 pc=0 (now vld=%b code=%0d pc=%0d)",
                  bad, opValid, opCode, romAddr);
      end
      opReady = 1'b1;
      wait_halt("stall_halt", 200);
      n_cmp++;
      if (op_log.size() != 2 || op_log[0] != 0 || op_log[1] != 4) begin
         n_bad++;
         $display("FAIL stall_ops: got %p, required 0,4 exactly once each", op_log);
      end
      n_cmp++;
      if (romAddr !== 4'd2) begin
         n_bad++;
         $display("FAIL stall_pc: got %0d, required 2", romAddr);
      end
   endtask

   task automatic test_skip();
      start("[+.]-", 1'b1, 1'b1, 1'b1);
      wait_halt("skip_halt", 300);
      n_cmp++;
      if (op_log.size() != 1 || op_log[0] != 1) begin
         n_bad++;
         $display("FAIL skip_ops: got %p, required single 1", op_log);
      end
      n_cmp++;
      if ({error, romAddr} !== {1'b0, 4'd5}) begin
         n_bad++;
         $display("FAIL skip_end: err=%b pc=%0d, required 0/5", error, romAddr);
      end
   endtask

   task automatic test_loops();
      int bad;
      start("+[.+]>-[.-]", 1'b1, 1'b0, 1'b0);
      wait_halt("loop_halt", 30000);
      n_cmp++;
      if (out_log.size() != 510) begin
         n_bad++;
         $display("FAIL loop_count: got %0d outputs, required 510", out_log.size());
      end
      bad = 0;
      for (int i = 0; i < 255 && i < out_log.size(); i++) if (out_log[i] != i + 1) bad++;
      for (int i = 0; i < 255 && 255 + i < out_log.size(); i++) if (out_log[255 + i] != 255 - i) bad++;
      n_cmp++;
      if (bad != 0) begin
         n_bad++;
         $display("FAIL loop_values: %0d outputs differ from 1..255,255..1", bad);
      end
      n_cmp++;
      if ({error, romAddr} !== {1'b0, 4'd11}) begin
         n_bad++;
         $display("FAIL loop_end: err=%b pc=%0d, required 0/11", error, romAddr);
      end
   endtask

   task automatic test_errors();
      start("]", 1'b1, 1'b1, 1'b0);
      wait_halt("err_close_halt", 100);
      n_cmp++;
      if (error !== 1'b1) begin
         n_bad++;
         $display("FAIL err_close: error=%b, required 1", error);
      end
      start("[[", 1'b1, 1'b1, 1'b1);
      wait_halt("err_open_halt", 100);
      n_cmp++;
      if ({error, op_log.size() == 0} !== 2'b11) begin
         n_bad++;
         $display("FAIL err_open: error=%b ops=%0d, required 1/0", error, op_log.size());
      end
   endtask

   task automatic test_wrap();
      start("                ", 1'b1, 1'b0, 1'b0);
      wait_halt("wrap_halt", 100);
      n_cmp++;
      if ({error, romAddr} !== {1'b0, 4'd15}) begin
         n_bad++;
         $display("FAIL wrap_nop: err=%b pc=%0d, required 0/15", error, romAddr);
      end
      start("               ]", 1'b1, 1'b1, 1'b1);
      wait_halt("wrap_close_halt", 100);
      n_cmp++;
      if ({error, romAddr} !== {1'b0, 4'd15}) begin
         n_bad++;
         $display("FAIL wrap_close: err=%b pc=%0d, required 0/15", error, romAddr);
      end
   endtask

   initial begin
      reset    = 1'b1;
      opReady  = 1'b0;
      cz_force = 1'b1;
      cz_val   = 1'b0;
      test_reset();
      test_basic();
      test_stall();
      test_skip();
      test_loops();
      test_errors();
      test_wrap();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
